// File: rtl/sfp_accum.sv
// Special-function accumulator: sums col-lane psum rows over several passes into a
// row buffer, then drains the totals over valid/ready with optional per-lane ReLU.
module sfp_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 32,
  parameter int aw      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in,
  input  logic                     valid_in,
  input  logic                     start,
  input  logic [aw:0]              num_rows,
  input  logic [7:0]               num_pass,
  input  logic                     relu_en,
  output logic [psum_bw*col-1:0]   out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err_drop
);

  localparam int depth = 2**aw;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [aw-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [7:0]             pass_cnt_reg, passes_reg;
  logic [aw:0]            rows_reg;
  logic                   relu_reg;
  logic                   done_reg, err_drop_reg;

  // Read-modify-write every cycle at full rate, so the row store uses
  // combinational reads; the drained row is visible the cycle after the last beat.
  logic [psum_bw*col-1:0] row_mem [depth];
  logic [psum_bw*col-1:0] cur_row, wr_row, rd_row;

  logic [aw:0]            rows_cfg;
  logic [7:0]             passes_cfg;
  logic                   beat_acc, last_row_wr, last_pass, accept, last_row_rd;

  always_comb begin
    rows_cfg = num_rows;
    if (num_rows == '0)
      rows_cfg = (aw+1)'(1);
    else if (num_rows > (aw+1)'(depth))
      rows_cfg = (aw+1)'(depth);
    passes_cfg = (num_pass == 8'd0) ? 8'd1 : num_pass;
  end

  assign beat_acc    = (state_reg == ACCUM) && valid_in;
  assign last_row_wr = ({1'b0, wr_ptr_reg} == (rows_reg - 1'b1));
  assign last_pass   = (pass_cnt_reg == (passes_reg - 8'd1));
  assign accept      = (state_reg == DRAIN) && out_ready;
  assign last_row_rd = ({1'b0, rd_ptr_reg} == (rows_reg - 1'b1));

  assign cur_row = row_mem[wr_ptr_reg];
  assign rd_row  = row_mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      logic [psum_bw-1:0] in_lane, cur_lane, rd_lane;
      assign in_lane  = in[gi*psum_bw +: psum_bw];
      assign cur_lane = cur_row[gi*psum_bw +: psum_bw];
      assign rd_lane  = rd_row[gi*psum_bw +: psum_bw];
      // Pass 0 overwrites, so stale contents from an earlier job never leak in.
      assign wr_row[gi*psum_bw +: psum_bw] =
        (pass_cnt_reg == 8'd0) ? in_lane : cur_lane + in_lane;
      assign out[gi*psum_bw +: psum_bw] =
        ((state_reg != DRAIN) || (relu_reg && rd_lane[psum_bw-1])) ? '0 : rd_lane;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (beat_acc && last_row_wr && last_pass) state_next = DRAIN;
      DRAIN:   if (accept && last_row_rd) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pass_cnt_reg <= '0;
      rows_reg     <= (aw+1)'(1);
      passes_reg   <= 8'd1;
      relu_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_drop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= accept && last_row_rd;
      err_drop_reg <= valid_in && (state_reg != ACCUM);
      if ((state_reg == IDLE) && start) begin
        rows_reg     <= rows_cfg;
        passes_reg   <= passes_cfg;
        relu_reg     <= relu_en;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        pass_cnt_reg <= '0;
      end
      if (beat_acc) begin
        if (last_row_wr) begin
          wr_ptr_reg   <= '0;
          pass_cnt_reg <= pass_cnt_reg + 8'd1;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
      end
      if (accept)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc)
      row_mem[wr_ptr_reg] <= wr_row;
  end

  assign out_valid = (state_reg == DRAIN);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err_drop  = err_drop_reg;

endmodule

// File: tb/tb_sfp_accum.sv
// Directed bench for sfp_accum: expected rows are queued when a job is driven
// and popped by a monitor as the drain handshakes them out.
module tb_sfp_accum;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] in = '0;
  logic         valid_in = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   num_rows = '0;
  logic [7:0]   num_pass = '0;
  logic         relu_en = 1'b0;
  logic [255:0] out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;
  logic         err_drop;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int done_cnt   = 0;
  int row_cnt    = 0;
  logic [255:0] exp_q[$];
  logic [255:0] held = '0;
  logic         stall_prev = 1'b0;

  always #5 clk = ~clk;

  sfp_accum dut (
    .clk(clk), .reset(reset), .in(in), .valid_in(valid_in), .start(start),
    .num_rows(num_rows), .num_pass(num_pass), .relu_en(relu_en),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err_drop(err_drop)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] row_all(input logic [31:0] v);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int rows, input int passes, input logic relu);
    num_rows = 5'(rows);
    num_pass = 8'(passes);
    relu_en  = relu;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic beat(input logic [255:0] r);
    in       = r;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int jobs);
    bit got = 0;
    for (int i = 0; i < 500; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("done_seen", got, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("out_valid_at_done", out_valid, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("done_count", done_cnt, jobs);
  endtask

  // Monitor: pops one expected row per accepted handshake; checks hold during stalls.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (stall_prev && out_valid) check("hold_stable", out, held);
      if (out_valid && out_ready) begin
        assert_cnt++;
        assert (exp_q.size() > 0) else begin
          fail_cnt++;
          $error("FAIL unexpected_row observed=%h expected=none", out);
        end
        if (exp_q.size() > 0) begin
          $display("row %0d accepted out=%h", row_cnt, out);
          check("drain_row", out, exp_q.pop_front());
        end
        row_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] r, a, b;
    tick(); tick();
    reset = 1'b0;
    check("reset_out", out, '0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err_drop", err_drop, 1'b0);

    // Single pass
    exp_q.push_back(row_all(32'd5));
    exp_q.push_back(row_all(32'hFFFFFFFD));
    start_job(2, 1, 1'b0);
    beat(row_all(32'd5));
    beat(row_all(-32'sd3));
    check("out_valid_after_last", out_valid, 1'b1);
    wait_done(0, 1);

    // Accumulate 9 passes over 4 rows
    for (int rr = 0; rr < 4; rr++) begin
      for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(9 * (rr * 10 + k));
      exp_q.push_back(r);
    end
    start_job(4, 9, 1'b0);
    for (int p = 0; p < 9; p++)
      for (int rr = 0; rr < 4; rr++) begin
        for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(rr * 10 + k);
        beat(r);
      end
    check("out_valid_after_last", out_valid, 1'b1);
    wait_done(0, 2);

    // ReLU and wrap, rows = 1
    a = '0; b = '0; r = '0;
    a[31:0] = 32'h7FFFFFFF; b[31:0]   = 32'h7FFFFFFF;
    a[63:32] = -32'sd4;     b[63:32]  = 32'd1;
    a[95:64] = 32'd3;       b[95:64]  = 32'd4;
    a[127:96] = 32'd100;    b[127:96] = 32'd200;
    r[95:64] = 32'd7;
    r[127:96] = 32'd300;
    exp_q.push_back(r);
    start_job(1, 2, 1'b1);
    beat(a);
    check("busy_mid_rows1", busy, 1'b1);
    check("no_drain_yet", out_valid, 1'b0);
    beat(b);
    check("out_valid_after_last", out_valid, 1'b1);
    wait_done(0, 3);

    // Backpressure, rows = 3
    for (int rr = 0; rr < 3; rr++) begin
      for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(rr * 100 + k - 50);
      exp_q.push_back(r);
    end
    start_job(3, 1, 1'b0);
    for (int rr = 0; rr < 3; rr++) begin
      for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(rr * 100 + k - 50);
      beat(r);
    end
    wait_done(1, 4);

    // Illegal traffic
    in = row_all(32'd99);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("err_drop_idle", err_drop, 1'b1);
    tick();
    check("err_drop_clear", err_drop, 1'b0);
    check("idle_no_valid", out_valid, 1'b0);
    exp_q.push_back(row_all(32'd11));
    exp_q.push_back(row_all(32'd22));
    num_rows = 5'd2; num_pass = 8'd2; relu_en = 1'b0;
    start = 1'b1; valid_in = 1'b1; in = row_all(32'd77);
    tick();
    start = 1'b0; valid_in = 1'b0;
    check("err_drop_start_beat", err_drop, 1'b1);
    check("busy_start_beat", busy, 1'b1);
    in = row_all(32'd1); valid_in = 1'b1;
    start = 1'b1; num_rows = 5'd1; num_pass = 8'd1;
    tick();
    start = 1'b0; valid_in = 1'b0;
    check("err_drop_legal_beat", err_drop, 1'b0);
    beat(row_all(32'd2));
    beat(row_all(32'd10));
    check("start_ignored_accum", out_valid, 1'b0);
    beat(row_all(32'd20));
    check("out_valid_after_last", out_valid, 1'b1);
    out_ready = 1'b0;
    in = row_all(32'd555); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("err_drop_drain", err_drop, 1'b1);
    out_ready = 1'b1;
    wait_done(0, 5);

    // Reset mid-ACCUM, then a fresh job
    start_job(4, 2, 1'b0);
    for (int i = 0; i < 5; i++) beat(row_all(32'(1000 + i)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    exp_q.push_back(row_all(32'd11));
    exp_q.push_back(row_all(-32'sd22));
    start_job(2, 1, 1'b0);
    beat(row_all(32'd11));
    beat(row_all(-32'sd22));
    wait_done(0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
